// File: rtl/dram_responder.sv
// dram_responder
//   Word-addressed memory endpoint for the layer engines (conv, pool, fc).
//   Writes commit at the clock edge ending the request cycle; reads return
//   after READ_LAT cycles through a {valid, data} shift register. A read and
//   a write to the same address in one cycle return the new write data.
//   Addresses at or above MEM_DEPTH are out of range: reads return 0 (still
//   flagged valid), writes are dropped, and either case sets sticky err_oob.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   dram_en_rd, addr_in read request and read word address
//   data_in, dram_valid read data and its qualifier (data holds when idle)
//   dram_en_wr          write request
//   addr_out, data_out  write word address and write data
//   err_oob             sticky out-of-range access flag
//   rd_cnt, wr_cnt      saturating in-range access counters
//
// Configuration
//   DRAM_STATS_EN : when defined, rd_cnt/wr_cnt count accepted in-range
//                   reads/writes; when undefined they are tied to 0 and no
//                   counter flops exist.
//
// Memory contents are not reset. READ_LAT legal range is 1..4.
module dram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_DEPTH  = 262144,
  parameter int READ_LAT   = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  dram_valid,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  err_oob,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Full-width unsigned compare so high address bits never alias into range.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < 64'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a);
  endfunction

  logic                  rd_ok;
  logic                  wr_ok;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_ok     = dram_en_rd & in_range(addr_in);
  assign wr_ok     = dram_en_wr & in_range(addr_out);
  // A write presented while reset is held is discarded.
  assign wr_commit = wr_ok & ~rst;

  // Write-first bypass keeps engine read-modify-write chains coherent;
  // out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if (wr_ok && (addr_out == addr_in)) rd_word = data_out;
      else                                rd_word = mem[idx(addr_in)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit) mem[idx(addr_out)] <= data_out;
  end

  // Read pipeline: stage 0 captures the word at issue, so later writes to
  // the same address cannot change a read already in flight. Data only
  // advances alongside a valid, which makes the last stage hold its value.
  logic                  vld_p  [READ_LAT];
  logic [DATA_WIDTH-1:0] data_p [READ_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= dram_en_rd;
      if (dram_en_rd) data_p[0] <= rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign dram_valid = vld_p[READ_LAT-1];
  assign data_in    = data_p[READ_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if ((dram_en_rd && !in_range(addr_in)) ||
                 (dram_en_wr && !in_range(addr_out))) begin
      err_oob <= 1'b1;
    end
  end

`ifdef DRAM_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_ok) rd_cnt <= sat_inc(rd_cnt);
      if (wr_ok) wr_cnt <= sat_inc(wr_cnt);
    end
  end
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
